// File: rtl/dds_pkg.sv
// Shared types and default sizing for the DDS phase generator.
package dds_pkg;

  localparam int unsigned ACC_W_DEF       = 32;
  localparam int unsigned ADDR_W_DEF      = 11;
  localparam int unsigned LUT_LATENCY_DEF = 3;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PEND
  } state_t;

  typedef struct packed {
    logic [ACC_W_DEF-1:0]  ftw;
    logic [ADDR_W_DEF-1:0] poff;
    logic                  at_wrap;
    logic                  clr_phase;
  } cfg_t;

endpackage

// File: rtl/dds_valid_delay.sv
// N-stage shift register (N >= 1) with synchronous reset; lines a valid flag up with a fixed-latency stage.
module dds_valid_delay #(
  parameter int unsigned N = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  logic [N-1:0] sr;

  always_ff @(posedge clk) begin
    if (rst) begin
      sr <= '0;
    end else begin
      sr[0] <= din;
      for (int unsigned i = 1; i < N; i++) begin
        sr[i] <= sr[i-1];
      end
    end
  end

  assign dout = sr[N-1];

endmodule

// File: rtl/dds_phase_gen.sv
// Phase-accumulator NCO front end: FTW integration, phase offset, and immediate or
// phase-continuous (at-wrap) reconfiguration over a valid/ready handshake.
module dds_phase_gen
  import dds_pkg::*;
#(
  parameter int unsigned ACC_W       = ACC_W_DEF,
  parameter int unsigned ADDR_W      = ADDR_W_DEF,
  parameter int unsigned LUT_LATENCY = LUT_LATENCY_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [ACC_W-1:0]  cfg_ftw,
  input  logic [ADDR_W-1:0] cfg_poff,
  input  logic              cfg_at_wrap,
  input  logic              cfg_clr_phase,
  output logic [ADDR_W-1:0] addr_out,
  output logic              addr_valid,
  output logic              wrap,
  output logic              lut_valid
);

  state_t            state, state_next;
  logic [ACC_W-1:0]  acc, ftw_act, ftw_sh, acc_next, ftw_next;
  logic [ADDR_W-1:0] poff_act, poff_sh, poff_next;
  logic              clr_sh;
  logic [ACC_W:0]    sum;
  logic              carry, xfer, apply_imm, apply_pend, load_sh, wrap_next;

  assign sum       = {1'b0, acc} + {1'b0, ftw_act};
  assign carry     = sum[ACC_W];
  assign cfg_ready = !rst && (state != PEND);
  assign xfer      = cfg_valid && cfg_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    apply_imm  = 1'b0;
    apply_pend = 1'b0;
    load_sh    = 1'b0;
    case (state)
      IDLE: begin
        if (xfer)   apply_imm  = 1'b1;
        if (enable) state_next = RUN;
      end
      RUN: begin
        if (xfer && cfg_at_wrap) begin
          load_sh    = 1'b1;
          state_next = PEND;
        end else begin
          if (xfer)    apply_imm  = 1'b1;
          if (!enable) state_next = IDLE;
        end
      end
      PEND: begin
        // The wrapping add itself still uses the old FTW; the swap lands on the same edge.
        if (enable && carry) begin
          apply_pend = 1'b1;
          state_next = RUN;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    acc_next  = acc;
    ftw_next  = ftw_act;
    poff_next = poff_act;
    wrap_next = 1'b0;
    if (enable) begin
      acc_next  = sum[ACC_W-1:0];
      wrap_next = carry;
    end
    if (apply_imm) begin
      ftw_next  = cfg_ftw;
      poff_next = cfg_poff;
      // An immediate clear replaces the add, so no carry can be reported.
      if (cfg_clr_phase) begin
        acc_next  = '0;
        wrap_next = 1'b0;
      end
    end
    if (apply_pend) begin
      ftw_next  = ftw_sh;
      poff_next = poff_sh;
      if (clr_sh) acc_next = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc        <= '0;
      ftw_act    <= '0;
      poff_act   <= '0;
      ftw_sh     <= '0;
      poff_sh    <= '0;
      clr_sh     <= 1'b0;
      addr_out   <= '0;
      addr_valid <= 1'b0;
      wrap       <= 1'b0;
    end else begin
      acc      <= acc_next;
      ftw_act  <= ftw_next;
      poff_act <= poff_next;
      if (load_sh) begin
        ftw_sh  <= cfg_ftw;
        poff_sh <= cfg_poff;
        clr_sh  <= cfg_clr_phase;
      end
      if (enable) addr_out <= acc_next[ACC_W-1 -: ADDR_W] + poff_act;
      addr_valid <= enable;
      wrap       <= wrap_next;
    end
  end

  dds_valid_delay #(
    .N(LUT_LATENCY)
  ) u_valid_delay (
    .clk (clk),
    .rst (rst),
    .din (addr_valid),
    .dout(lut_valid)
  );

endmodule

// File: tb/tb_dds_phase_gen.sv
// Directed bench for dds_phase_gen: ramp/wrap, immediate and at-wrap config, offsets, reset.
module tb_dds_phase_gen;
  import dds_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [31:0] cfg_ftw = '0;
  logic [10:0] cfg_poff = '0;
  logic        cfg_at_wrap = 1'b0;
  logic        cfg_clr_phase = 1'b0;
  logic [10:0] addr_out;
  logic        addr_valid, wrap, lut_valid;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dds_phase_gen #(
    .ACC_W(32),
    .ADDR_W(11),
    .LUT_LATENCY(3)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_ftw      (cfg_ftw),
    .cfg_poff     (cfg_poff),
    .cfg_at_wrap  (cfg_at_wrap),
    .cfg_clr_phase(cfg_clr_phase),
    .addr_out     (addr_out),
    .addr_valid   (addr_valid),
    .wrap         (wrap),
    .lut_valid    (lut_valid)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input cfg_t c);
    cfg_valid     = 1'b1;
    cfg_ftw       = c.ftw;
    cfg_poff      = c.poff;
    cfg_at_wrap   = c.at_wrap;
    cfg_clr_phase = c.clr_phase;
  endtask

  // Reset, then load an immediate config while idle; leaves acc = 0, enable low.
  task automatic restart(input logic [31:0] ftw, input logic [10:0] poff);
    rst = 1'b1; enable = 1'b0; cfg_valid = 1'b0;
    tick(); tick();
    rst = 1'b0;
    offer('{ftw: ftw, poff: poff, at_wrap: 1'b0, clr_phase: 1'b0});
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic run(input int n);
    enable = 1'b1;
    repeat (n) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    checks++; if (addr_out !== 11'd0) begin failures++; $display("FAIL reset_addr got=%0d exp=0", addr_out); end
    checks++; if ({addr_valid, wrap, lut_valid} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {addr_valid, wrap, lut_valid}); end
    checks++; if (cfg_ready !== 1'b0) begin failures++; $display("FAIL reset_ready_in_rst got=%b exp=0", cfg_ready); end
    rst = 1'b0;
    #1;
    checks++; if (cfg_ready !== 1'b1) begin failures++; $display("FAIL reset_ready_after got=%b exp=1", cfg_ready); end
  endtask

  task automatic test_ramp();
    logic [10:0] exp_addr;
    int wraps;
    wraps = 0;
    restart(32'h0020_0000, 11'd0);
    enable = 1'b1;
    for (int k = 1; k <= 2100; k++) begin
      tick();
      exp_addr = 11'(k % 2048);
      checks++; if (addr_out !== exp_addr) begin failures++; $display("FAIL ramp_addr k=%0d got=%0d exp=%0d", k, addr_out, exp_addr); end
      checks++; if (wrap !== (k == 2048)) begin failures++; $display("FAIL ramp_wrap k=%0d got=%b exp=%b", k, wrap, (k == 2048)); end
      if (wrap === 1'b1) wraps++;
      if (k <= 6) begin
        checks++; if (lut_valid !== (k >= 4)) begin failures++; $display("FAIL ramp_lut_valid k=%0d got=%b exp=%b", k, lut_valid, (k >= 4)); end
      end
    end
    checks++; if (wraps != 1) begin failures++; $display("FAIL ramp_wrap_count got=%0d exp=1", wraps); end
  endtask

  // Continues from test_ramp: running at step 1, addr_out = 52.
  task automatic test_imm_cfg();
    logic [10:0] exp_seq [3];
    exp_seq = '{11'd53, 11'd55, 11'd57};
    offer('{ftw: 32'h0040_0000, poff: 11'd0, at_wrap: 1'b0, clr_phase: 1'b0});
    for (int i = 0; i < 3; i++) begin
      tick();
      cfg_valid = 1'b0;
      checks++; if (addr_out !== exp_seq[i]) begin failures++; $display("FAIL imm_addr i=%0d got=%0d exp=%0d", i, addr_out, exp_seq[i]); end
      checks++; if (cfg_ready !== 1'b1) begin failures++; $display("FAIL imm_ready i=%0d got=%b exp=1", i, cfg_ready); end
    end
  endtask

  task automatic test_poff();
    logic [10:0] poffs [2];
    logic [10:0] exps [2];
    poffs = '{11'd512, 11'd2000};
    exps  = '{11'd613, 11'd53};
    for (int j = 0; j < 2; j++) begin
      restart(32'h0020_0000, 11'd0);
      run(99);
      offer('{ftw: 32'h0020_0000, poff: poffs[j], at_wrap: 1'b0, clr_phase: 1'b0});
      tick();
      cfg_valid = 1'b0;
      checks++; if (addr_out !== 11'd100) begin failures++; $display("FAIL poff_xfer j=%0d got=%0d exp=100", j, addr_out); end
      tick();
      checks++; if (addr_out !== exps[j]) begin failures++; $display("FAIL poff_next j=%0d got=%0d exp=%0d", j, addr_out, exps[j]); end
    end
  endtask

  task automatic test_at_wrap();
    logic [10:0] exp_after [4];
    exp_after = '{11'd0, 11'd1, 11'd1, 11'd2};
    restart(32'h0020_0000, 11'd0);
    run(2040);
    offer('{ftw: 32'h0010_0000, poff: 11'd0, at_wrap: 1'b1, clr_phase: 1'b0});
    tick();
    checks++; if (addr_out !== 11'd2041) begin failures++; $display("FAIL atw_xfer_addr got=%0d exp=2041", addr_out); end
    // Keep offering a different word while pending; it must not be taken.
    offer('{ftw: 32'h0080_0000, poff: 11'd7, at_wrap: 1'b0, clr_phase: 1'b0});
    for (int k = 2042; k <= 2047; k++) begin
      checks++; if (cfg_ready !== 1'b0) begin failures++; $display("FAIL atw_ready_pend k=%0d got=%b exp=0", k, cfg_ready); end
      tick();
      checks++; if (wrap !== 1'b0 || addr_out !== 11'(k)) begin failures++; $display("FAIL atw_pend k=%0d got=%0d/%b exp=%0d/0", k, addr_out, wrap, k); end
    end
    tick();
    checks++; if (wrap !== 1'b1 || addr_out !== 11'd0) begin failures++; $display("FAIL atw_wrap_sample got=%0d/%b exp=0/1", addr_out, wrap); end
    checks++; if (cfg_ready !== 1'b1) begin failures++; $display("FAIL atw_ready_back got=%b exp=1", cfg_ready); end
    cfg_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (addr_out !== exp_after[i] || wrap !== 1'b0 || addr_valid !== 1'b1) begin failures++; $display("FAIL atw_half_step i=%0d got=%0d/%b/%b exp=%0d/0/1", i, addr_out, wrap, addr_valid, exp_after[i]); end
    end
  endtask

  task automatic test_pend_hold_clr();
    logic [10:0] exp_after [3];
    exp_after = '{11'd300, 11'd301, 11'd302};
    restart(32'h0020_0001, 11'd0);
    run(2040);
    offer('{ftw: 32'h001F_F800, poff: 11'd300, at_wrap: 1'b1, clr_phase: 1'b1});
    tick();
    cfg_valid = 1'b0;
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++; if (addr_out !== 11'd2041 || addr_valid !== 1'b0 || wrap !== 1'b0) begin failures++; $display("FAIL hold_frozen i=%0d got=%0d/%b/%b exp=2041/0/0", i, addr_out, addr_valid, wrap); end
      checks++; if (lut_valid !== (i < 3)) begin failures++; $display("FAIL hold_lut_gap i=%0d got=%b exp=%b", i, lut_valid, (i < 3)); end
      checks++; if (cfg_ready !== 1'b0) begin failures++; $display("FAIL hold_ready i=%0d got=%b exp=0", i, cfg_ready); end
    end
    run(6);
    checks++; if (addr_out !== 11'd2047 || wrap !== 1'b0) begin failures++; $display("FAIL hold_resume got=%0d/%b exp=2047/0", addr_out, wrap); end
    tick();
    checks++; if (addr_out !== 11'd0 || wrap !== 1'b1) begin failures++; $display("FAIL hold_wrap got=%0d/%b exp=0/1", addr_out, wrap); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (addr_out !== exp_after[i]) begin failures++; $display("FAIL hold_clr_restart i=%0d got=%0d exp=%0d", i, addr_out, exp_after[i]); end
    end
  endtask

  task automatic test_reset_pend();
    restart(32'h0020_0000, 11'd0);
    run(2040);
    offer('{ftw: 32'h0010_0000, poff: 11'd5, at_wrap: 1'b1, clr_phase: 1'b0});
    tick();
    cfg_valid = 1'b0;
    checks++; if (cfg_ready !== 1'b0) begin failures++; $display("FAIL rstp_pending got=%b exp=0", cfg_ready); end
    rst = 1'b1;
    tick();
    checks++; if ({addr_out, addr_valid, wrap, lut_valid, cfg_ready} !== 15'd0) begin failures++; $display("FAIL rstp_outputs got=%0d/%b/%b/%b/%b exp=0/0/0/0/0", addr_out, addr_valid, wrap, lut_valid, cfg_ready); end
    rst = 1'b0;
    enable = 1'b0;
    #1;
    checks++; if (cfg_ready !== 1'b1) begin failures++; $display("FAIL rstp_ready got=%b exp=1", cfg_ready); end
    run(3);
    checks++; if (addr_out !== 11'd0 || addr_valid !== 1'b1 || wrap !== 1'b0) begin failures++; $display("FAIL rstp_cfg_lost got=%0d/%b/%b exp=0/1/0", addr_out, addr_valid, wrap); end
    enable = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_ramp();
    test_imm_cfg();
    test_poff();
    test_at_wrap();
    test_pend_hold_clr();
    test_reset_pend();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dds_phase_gen.md
# dds_phase_gen

Phase-accumulator NCO front end for the DDS chain. Integrates a frequency tuning word (FTW) each enabled cycle, adds a phase offset, and drives the 11-bit phase address into the sine lookup stage directly downstream. Accepts new FTW/offset settings over a valid/ready handshake, applied either immediately or phase-continuously at the next accumulator wrap. Also produces a valid flag delayed to line up with the lookup's 3-clock output.

## Interface
- ACC_W, 32, accumulator width; requires ACC_W ≥ ADDR_W
- ADDR_W, 11, phase address width fed to the lookup
- LUT_LATENCY, 3, downstream lookup latency in clocks
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- enable  in  1  advance the accumulator this cycle
- cfg_valid  in  1  config word offered
- cfg_ready  out  1  config can be accepted
- cfg_ftw  in  ACC_W  new tuning word
- cfg_poff  in  ADDR_W  new phase offset, in address LSBs
- cfg_at_wrap  in  1  0 = apply immediately; 1 = apply at next wrap
- cfg_clr_phase  in  1  zero the accumulator when the config is applied
- addr_out  out  ADDR_W  phase address to the lookup
- addr_valid  out  1  addr_out holds a fresh sample
- wrap  out  1  one-cycle pulse: the accumulator carried out this sample
- lut_valid  out  1  addr_valid delayed LUT_LATENCY clocks; qualifies the lookup output

## Operation
- Registers:
  - acc, ftw_act, poff_act: the active accumulator, tuning word and offset.
  - ftw_sh, poff_sh, clr_sh: shadow copies for a pending config.
  - state: one of IDLE, RUN, PEND.
- Accumulator: when enable=1, acc <= (acc + ftw_act) mod 2^ACC_W. The carry out of that addition is the wrap event. When enable=0, acc holds.
- Address: addr_out <= (acc_next[ACC_W-1 -: ADDR_W] + poff_act) mod 2^ADDR_W. It is registered and updates only when enable=1. addr_valid <= enable. wrap <= carry & enable.
- Handshake: a transfer occurs when cfg_valid & cfg_ready. cfg_ready = !rst && state != PEND. cfg_* is sampled only on a transfer.
- States:
  - IDLE (enable=0, nothing pending): every accepted config applies immediately, including cfg_at_wrap=1. enable=1 → RUN.
  - RUN:
    - cfg_at_wrap=0 transfer: apply next cycle; stay in RUN.
    - cfg_at_wrap=1 transfer: load the shadows → PEND.
    - enable=0 → IDLE.
  - PEND: on the first enabled cycle whose addition wraps, that addition uses the old ftw_act. The shadows are copied into the active registers at the same edge; if clr_sh is set, acc <= 0 instead of the sum. Then → RUN (or IDLE if enable=0 next). If enable=0 while in PEND, stay in PEND with acc frozen; the pending config is not dropped.
- Apply: ftw_act and poff_act take the new values. If clear is requested, acc <= 0 and enable's add is skipped that cycle.
- FTW=0 is legal: acc stays constant and wrap never fires. A pending config under FTW=0 stays pending until rst.
- Reset:
  - acc, ftw_act, poff_act, all shadows = 0.
  - addr_out = 0; addr_valid, wrap, lut_valid = 0.
  - state = IDLE.
  - cfg_ready = 0 while rst=1.
  - rst wins over every simultaneous event. A pending config is discarded.

## Timing
- enable sampled high at edge n → addr_out/addr_valid updated at edge n+1.
- lut_valid at edge n+1+LUT_LATENCY, aligned with the lookup's value.
- Immediate config transferred at edge n → the new FTW is first used in the addition at edge n+1. The new offset is first visible in addr_out at edge n+1.
- At-wrap config: the wrap pulse and the first new-FTW sample are consecutive samples, with no gap or repeat.
- cfg_ready drops the cycle after a PEND transfer. It rises the cycle after the apply edge.
- lut_valid pipeline runs continuously; enable gaps propagate as lut_valid gaps.

## Structure
- Package dds_pkg holds:
  - constants ACC_W_DEF=32, ADDR_W_DEF=11, LUT_LATENCY_DEF=3;
  - state enum {IDLE, RUN, PEND};
  - a cfg struct {ftw, poff, at_wrap, clr_phase}.
- Sub-module dds_valid_delay: an N-stage shift register with synchronous reset, used for lut_valid.

## Test plan
- ftw=0x0020_0000, poff=0, enable held → addr_out goes 1,2,3,… each cycle, wraps 2047→0, wrap pulses once every 2048 samples; lut_valid trails addr_valid by 3 clocks.
- Running at ftw=0x0020_0000, immediate cfg ftw=0x0040_0000 → the step becomes 2 from the next sample; cfg_ready stays 1.
- Running, cfg_at_wrap=1 with ftw=0x0010_0000 → cfg_ready=0 until the wrap sample; the sample after the wrap steps by 0.5 address (every other cycle +1); cfg_ready returns to 1 the next cycle.
- poff=512 applied while at addr 100 → the next addr_out=613 (101+512); poff=2000 at addr 100 → the next addr_out is (101+2000) mod 2048 = 53.
- PEND, enable dropped for 10 cycles then raised → acc frozen, no wrap, config held; applied at the first later wrap; with cfg_clr_phase=1 the address restarts at poff.
- rst asserted mid-PEND with enable=1 → the next cycle has all outputs 0, state IDLE, pending config lost; cfg_ready=1 the cycle after rst deasserts.
